// File: rtl/sequence_recorder_pkg.sv
`default_nettype none
// ============================================================================
// sequence_recorder_pkg : shared FSM state encoding and one-hot helper
// Rev 1.0
// ============================================================================
package sequence_recorder_pkg;

    localparam int c_ONEHOT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_WAIT_RELEASE = 3'd2,
        ST_WRITE        = 3'd3,
        ST_DONE         = 3'd4,
        ST_ERROR        = 3'd5
    } state_t;

    // Callers zero-extend narrower words; zero-extension keeps the test exact.
    function automatic logic is_onehot(input logic [c_ONEHOT_W-1:0] v);
        return (v != '0) && ((v & (v - c_ONEHOT_W'(1))) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_recorder_ram_sync.sv
`default_nettype none
// ============================================================================
// ram_sync : single-clock RAM, one write port, registered read-before-write port
// Rev 1.0
// ============================================================================
module ram_sync #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is never reset so it keeps the captured sequence across resets.
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Same-edge read sees the pre-write word because the write is non-blocking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sequence_recorder.sv
`default_nettype none
// ============================================================================
// sequence_recorder : captures one-hot button presses into RAM, serves readback
// Rev 1.0
// ============================================================================
module sequence_recorder
    import sequence_recorder_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic [ADDR_WIDTH-1:0] tamanho,
    input  logic [DATA_WIDTH-1:0] botoes,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  gravando,
    output logic                  pronto,
    output logic                  erro,
    output logic [ADDR_WIDTH:0]   contagem
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_dado;
    logic [ADDR_WIDTH-1:0] r_lim;
    logic [ADDR_WIDTH:0]   r_contagem;

    logic w_idle_like;
    logic w_start;
    logic w_press_onehot;
    logic w_last;
    logic w_we;

    assign w_idle_like    = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                            (r_state == ST_ERROR);
    assign w_start        = w_idle_like && iniciar;
    assign w_press_onehot = is_onehot(c_ONEHOT_W'(botoes));
    assign w_last         = (r_contagem == {1'b0, r_lim});
    assign w_we           = (r_state == ST_WRITE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (iniciar) begin
                    w_state_nxt = ST_WAIT_PRESS;
                end
            end
            ST_WAIT_PRESS: begin
                if (botoes == '0) begin
                    w_state_nxt = ST_WAIT_PRESS;
                end else if (w_press_onehot) begin
                    w_state_nxt = ST_WAIT_RELEASE;
                end else begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_WAIT_RELEASE: begin
                if (botoes == r_dado) begin
                    w_state_nxt = ST_WAIT_RELEASE;
                end else if (botoes == '0) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_ERROR;
                end
            end
            ST_WRITE: begin
                w_state_nxt = w_last ? ST_DONE : ST_WAIT_PRESS;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dado     <= '0;
            r_lim      <= '0;
            r_contagem <= '0;
        end else begin
            if (w_start) begin
                r_lim      <= tamanho;
                r_contagem <= '0;
            end
            if ((r_state == ST_WAIT_PRESS) && w_press_onehot) begin
                r_dado <= botoes;
            end
            if (w_we) begin
                r_contagem <= r_contagem + 1'b1;
            end
        end
    end

    // Only the low bits index the RAM; the count stops at lim+1 so no wrap occurs.
    ram_sync #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clock(clock),
        .reset(reset),
        .we   (w_we),
        .waddr(r_contagem[ADDR_WIDTH-1:0]),
        .wdata(r_dado),
        .raddr(rd_address),
        .rdata(data_out)
    );

    assign gravando = (r_state == ST_WAIT_PRESS) || (r_state == ST_WAIT_RELEASE) ||
                      (r_state == ST_WRITE);
    assign pronto   = (r_state == ST_DONE);
    assign erro     = (r_state == ST_ERROR);
    assign contagem = r_contagem;

endmodule
`default_nettype wire

// File: tb/tb_sequence_recorder.sv
`default_nettype none
// ============================================================================
// tb_sequence_recorder : randomized scoreboard bench for sequence_recorder
// Rev 1.0
// ============================================================================
module tb_sequence_recorder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] tamanho = '0;
    logic [3:0] botoes = '0;
    logic [3:0] rd_address = '0;
    logic [3:0] data_out;
    logic       gravando;
    logic       pronto;
    logic       erro;
    logic [4:0] contagem;

    sequence_recorder #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .tamanho   (tamanho),
        .botoes    (botoes),
        .rd_address(rd_address),
        .data_out  (data_out),
        .gravando  (gravando),
        .pronto    (pronto),
        .erro      (erro),
        .contagem  (contagem)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // kind 0: data_out, kind 1: {gravando,pronto,erro}, kind 2: contagem
    typedef struct {
        int         due;
        int         kind;
        logic [4:0] exp;
    } chk_t;

    chk_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference RAM image; 'known' marks entries the model has written.
    logic [3:0] mem_m [16];
    bit         known [16];

    task automatic expect_at(input int due, input int kind, input logic [4:0] exp);
        chk_t c;
        c.due  = due;
        c.kind = kind;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    initial begin : monitor
        chk_t       c;
        logic [4:0] act;
        string      nm;
        forever begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                c = sb.pop_front();
                case (c.kind)
                    0:       begin act = {1'b0, data_out};               nm = "data_out"; end
                    1:       begin act = {2'b0, gravando, pronto, erro}; nm = "flags";    end
                    default: begin act = contagem;                       nm = "contagem"; end
                endcase
                total++;
                if (act !== c.exp) begin
                    bad++;
                    $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, c.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic readback();
        for (int a = 0; a < 16; a++) begin
            rd_address = 4'(a);
            if (known[a]) expect_at(cyc + 1, 0, {1'b0, mem_m[a]});
            step();
        end
        step();
    endtask

    // One recording run. err_kind 1: invalid value while waiting for a press;
    // err_kind 2: changed value while holding. rst_at: async reset after that many writes.
    task automatic run(input int tam, input logic [3:0] seq [16], input int err_at,
                       input int err_kind, input logic [3:0] err_val, input int rst_at);
        int written;
        bit errd;
        written = 0;
        errd    = 0;
        tamanho = 4'(tam);
        iniciar = 1'b1;
        botoes  = '0;
        step();
        iniciar = 1'b0;
        expect_at(cyc, 1, 5'b00100);
        expect_at(cyc, 2, 5'd0);
        for (int i = 0; i <= tam; i++) begin
            if (i == rst_at) begin
                step();
                #2 reset = 1'b1;
                expect_at(cyc, 1, 5'd0);
                expect_at(cyc, 2, 5'd0);
                expect_at(cyc, 0, 5'd0);
                @(negedge clock);
                #1 reset = 1'b0;
                step();
                return;
            end
            if (err_kind == 1 && i == err_at) begin
                botoes = err_val;
                step();
                botoes = '0;
                errd   = 1;
                break;
            end
            botoes = seq[i];
            step();
            repeat ($urandom % 3) begin
                iniciar = 1'($urandom % 2);
                step();
            end
            iniciar = 1'b0;
            if (err_kind == 2 && i == err_at) begin
                botoes = err_val;
                step();
                botoes = '0;
                errd   = 1;
                break;
            end
            botoes = '0;
            step();
            // Release seen at this edge; the write lands on the next one.
            rd_address = 4'(i);
            if (known[i]) expect_at(cyc + 1, 0, {1'b0, mem_m[i]});
            expect_at(cyc + 2, 0, {1'b0, seq[i]});
            step();
            mem_m[i] = seq[i];
            known[i] = 1;
            written++;
            repeat (1 + $urandom % 2) step();
        end
        step();
        step();
        expect_at(cyc, 1, errd ? 5'b00001 : 5'b00010);
        expect_at(cyc, 2, errd ? 5'(written) : 5'(tam + 1));
        readback();
    endtask

    initial begin : stim
        logic [3:0] s [16];
        int         tam;
        int         kind;
        int         at;
        logic [3:0] v;

        step();
        step();
        expect_at(cyc, 1, 5'd0);
        expect_at(cyc, 2, 5'd0);
        expect_at(cyc, 0, 5'd0);
        @(negedge clock);
        #1 reset = 1'b0;
        step();

        for (int k = 0; k < 16; k++) s[k] = 4'd0;
        s[0] = 4'b0001; s[1] = 4'b0010; s[2] = 4'b0100; s[3] = 4'b1000;
        run(3, s, -1, 0, 4'd0, -1);

        for (int k = 0; k < 16; k++) s[k] = 4'b0100;
        run(15, s, -1, 0, 4'd0, -1);

        for (int k = 0; k < 16; k++) s[k] = 4'(1 << ($urandom % 4));
        run(7, s, 3, 1, 4'b0110, -1);

        s[0] = 4'b0010;
        run(5, s, 0, 2, 4'b0011, -1);

        for (int k = 0; k < 16; k++) s[k] = 4'(1 << ($urandom % 4));
        run(1, s, -1, 0, 4'd0, -1);

        for (int k = 0; k < 16; k++) s[k] = 4'(1 << ($urandom % 4));
        run(3, s, -1, 0, 4'd0, 2);
        readback();

        repeat (25) begin
            tam = int'($urandom % 16);
            for (int k = 0; k < 16; k++) s[k] = 4'(1 << ($urandom % 4));
            kind = int'($urandom % 4);
            kind = (kind < 2) ? 0 : kind - 1;
            at   = int'($urandom_range(0, tam));
            v    = 4'd0;
            if (kind == 1) begin
                do v = 4'($urandom % 16); while ($countones(v) < 2);
            end else if (kind == 2) begin
                do v = 4'($urandom % 16); while (v == 4'd0 || v == s[at]);
            end
            run(tam, s, at, kind, v, -1);
        end

        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
